// File: rtl/imem_boot_loader.sv
// Boot loader: assembles a length-prefixed little-endian byte stream into 32-bit
// instruction-memory writes and holds the fetch stage until the image is in place.
module imem_boot_loader #(
  parameter int AW             = 10,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter bit BOOT_ON_RESET  = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          boot_req,
  input  logic          byte_valid,
  input  logic [7:0]    byte_data,
  output logic          byte_ready,
  output logic          imem_we,
  output logic [AW-1:0] imem_waddr,
  output logic [31:0]   imem_wdata,
  output logic          core_hold,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int            TW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [16:0]   CAP   = 17'(1) << AW;

  typedef enum logic [2:0] {S_LEN0, S_LEN1, S_DATA, S_RELEASE, S_RUN, S_ERR} state_t;
  localparam state_t S_RESET = BOOT_ON_RESET ? S_LEN0 : S_RUN;

  state_t          state_q, state_d;
  logic [15:0]     nlen_q, nlen_d;
  logic [AW:0]     wcnt_q, wcnt_d;
  logic [1:0]      lane_q, lane_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic [23:0]     wbuf_q, wbuf_d;
  logic            we_q, we_d;
  logic [AW-1:0]   waddr_q, waddr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            ready_q, hold_q, busy_q, done_q, err_q;

  logic            xfer;
  logic [15:0]     n_full;
  logic [AW:0]     wcnt_inc;

  assign xfer     = byte_valid && ready_q;
  assign n_full   = {byte_data, nlen_q[7:0]};
  assign wcnt_inc = wcnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    nlen_d  = nlen_q;
    wcnt_d  = wcnt_q;
    lane_d  = lane_q;
    tcnt_d  = tcnt_q;
    wbuf_d  = wbuf_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_LEN0: begin
        if (xfer) begin
          nlen_d[7:0] = byte_data;
          state_d     = S_LEN1;
        end
      end
      S_LEN1, S_DATA: begin
        if (xfer) begin
          tcnt_d = '0;
          if (state_q == S_LEN1) begin
            nlen_d[15:8] = byte_data;
            wcnt_d       = '0;
            lane_d       = '0;
            state_d      = (n_full == 16'd0 || {1'b0, n_full} > CAP) ? S_ERR : S_DATA;
          end else if (lane_q == 2'd3) begin
            we_d    = 1'b1;
            waddr_d = wcnt_q[AW-1:0];
            wdata_d = {byte_data, wbuf_q};
            wcnt_d  = wcnt_inc;
            lane_d  = '0;
            if (17'(wcnt_inc) == {1'b0, nlen_q}) state_d = S_RELEASE;
          end else begin
            // Bytes enter at the top so b0 ends up in the low lane after three shifts.
            wbuf_d = {byte_data, wbuf_q[23:8]};
            lane_d = lane_q + 2'd1;
          end
        end else if (tcnt_q == TLAST) begin
          state_d = S_ERR;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      S_RELEASE: state_d = S_RUN;
      default: begin
        if (boot_req) begin
          state_d = S_LEN0;
          nlen_d  = '0;
          wcnt_d  = '0;
          lane_d  = '0;
          tcnt_d  = '0;
        end
      end
    endcase
  end

  // Status outputs are decoded from the next state so they are registered yet current.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RESET;
      nlen_q  <= '0;
      wcnt_q  <= '0;
      lane_q  <= '0;
      tcnt_q  <= '0;
      wbuf_q  <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      ready_q <= BOOT_ON_RESET;
      busy_q  <= BOOT_ON_RESET;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      nlen_q  <= nlen_d;
      wcnt_q  <= wcnt_d;
      lane_q  <= lane_d;
      tcnt_q  <= tcnt_d;
      wbuf_q  <= wbuf_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      ready_q <= (state_d == S_LEN0) || (state_d == S_LEN1) || (state_d == S_DATA);
      busy_q  <= (state_d == S_LEN0) || (state_d == S_LEN1) || (state_d == S_DATA) ||
                 (state_d == S_RELEASE);
      hold_q  <= (state_d != S_RUN);
      done_q  <= (state_q == S_RELEASE) && (state_d == S_RUN);
      err_q   <= (state_d == S_ERR);
    end
  end

  assign byte_ready = ready_q;
  assign imem_we    = we_q;
  assign imem_waddr = waddr_q;
  assign imem_wdata = wdata_q;
  assign core_hold  = hold_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: scoreboarded image loads, length/timeout errors,
// reload via boot_req and asynchronous reset mid-load.
module tb_imem_boot_loader;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n, boot_req, byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready, imem_we, core_hold, busy, done, err;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;
  logic          r_byte_ready, r_imem_we, r_core_hold, r_busy, r_done, r_err;
  logic [AW-1:0] r_imem_waddr;
  logic [31:0]   r_imem_wdata;

  always #5 clk = ~clk;

  imem_boot_loader #(.AW(AW), .TIMEOUT_CYCLES(16), .BOOT_ON_RESET(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .boot_req(boot_req), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready), .imem_we(imem_we),
    .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .core_hold(core_hold),
    .busy(busy), .done(done), .err(err)
  );

  imem_boot_loader #(.AW(AW), .TIMEOUT_CYCLES(16), .BOOT_ON_RESET(1'b0)) u_dut_run (
    .clk(clk), .rst_n(rst_n), .boot_req(1'b0), .byte_valid(1'b0),
    .byte_data(8'h00), .byte_ready(r_byte_ready), .imem_we(r_imem_we),
    .imem_waddr(r_imem_waddr), .imem_wdata(r_imem_wdata), .core_hold(r_core_hold),
    .busy(r_busy), .done(r_done), .err(r_err)
  );

  int n_chk = 0;
  int n_pass = 0;
  int we_cnt = 0;
  logic [AW+31:0] exp_q[$];
  logic [AW+31:0] mon_e;
  logic [31:0]    img_w [0:3];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && imem_we === 1'b1) begin
      we_cnt++;
      if (exp_q.size() == 0) begin
        check("we_unexpected", 64'(imem_we), 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("waddr", 64'(imem_waddr), 64'(mon_e[AW+31:32]));
        check("wdata", 64'(imem_wdata), 64'(mon_e[31:0]));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit rnd);
    bit xf;
    int k;
    xf = 1'b0;
    k  = 0;
    if (rnd) begin
      repeat ($urandom_range(0, 3)) begin
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
        @(negedge clk);
      end
    end
    byte_valid = 1'b1;
    byte_data  = b;
    while (!xf && k < 100) begin
      xf = byte_ready;
      @(negedge clk);
      k++;
    end
    byte_valid = 1'b0;
    byte_data  = 8'($urandom);
    if (!xf) check("xfer_stall", 64'(byte_ready), 64'd1);
  endtask

  task automatic send_wbyte(input int w, input int b, input bit rnd);
    if (b == 3) exp_q.push_back({w[AW-1:0], img_w[w]});
    send_byte(img_w[w][8*b +: 8], rnd);
  endtask

  task automatic req_pulse();
    boot_req = 1'b1;
    @(negedge clk);
    boot_req = 1'b0;
  endtask

  // Called in the cycle after the final byte was accepted.
  task automatic check_release();
    check("rel_we", 64'(imem_we), 64'd1);
    check("rel_hold", 64'(core_hold), 64'd1);
    check("rel_busy", 64'(busy), 64'd1);
    check("rel_done", 64'(done), 64'd0);
    @(negedge clk);
    check("run_done", 64'(done), 64'd1);
    check("run_hold", 64'(core_hold), 64'd0);
    check("run_busy", 64'(busy), 64'd0);
    check("run_ready", 64'(byte_ready), 64'd0);
    check("run_err", 64'(err), 64'd0);
    @(negedge clk);
    check("done_pulse", 64'(done), 64'd0);
    check("run_hold2", 64'(core_hold), 64'd0);
  endtask

  task automatic load(input int n, input bit rnd, input int brq_at);
    send_byte(n[7:0], rnd);
    send_byte(n[15:8], rnd);
    for (int w = 0; w < n; w++) begin
      for (int b = 0; b < 4; b++) begin
        if (w * 4 + b == brq_at) begin
          req_pulse();
          check("brq_ignored_busy", 64'(busy), 64'd1);
          check("brq_ignored_rdy", 64'(byte_ready), 64'd1);
        end
        send_wbyte(w, b, rnd);
      end
    end
    check_release();
  endtask

  task automatic len_error(input logic [15:0] n);
    int we0;
    we0 = we_cnt;
    req_pulse();
    check("req_err_clr", 64'(err), 64'd0);
    send_byte(n[7:0], 1'b0);
    send_byte(n[15:8], 1'b0);
    check("len_err", 64'(err), 64'd1);
    check("len_err_busy", 64'(busy), 64'd0);
    check("len_err_hold", 64'(core_hold), 64'd1);
    check("len_err_ready", 64'(byte_ready), 64'd0);
    check("len_err_no_we", 64'(we_cnt), 64'(we0));
  endtask

  initial begin
    int errs;
    boot_req   = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    rst_n      = 1'b1;
    #1 rst_n   = 1'b0;
    @(negedge clk);
    check("rst_we", 64'(imem_we), 64'd0);
    check("rst_waddr", 64'(imem_waddr), 64'd0);
    check("rst_wdata", 64'(imem_wdata), 64'd0);
    check("rst_hold", 64'(core_hold), 64'd1);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_busy", 64'(busy), 64'd1);
    check("rst_ready", 64'(byte_ready), 64'd1);
    check("rst0_busy", 64'(r_busy), 64'd0);
    check("rst0_ready", 64'(r_byte_ready), 64'd0);
    check("rst0_hold", 64'(r_core_hold), 64'd1);
    rst_n = 1'b1;
    @(negedge clk);
    check("run0_hold", 64'(r_core_hold), 64'd0);
    check("run0_done", 64'(r_done), 64'd0);
    check("boot_busy", 64'(busy), 64'd1);

    img_w[0] = 32'h0000_0013;
    img_w[1] = 32'h0010_0093;
    load(2, 1'b0, -1);

    req_pulse();
    check("req_hold", 64'(core_hold), 64'd1);
    check("req_busy", 64'(busy), 64'd1);
    check("req_err", 64'(err), 64'd0);
    load(2, 1'b1, -1);

    len_error(16'h0000);
    len_error(16'h0401);
    req_pulse();
    check("req_from_err", 64'(err), 64'd0);
    check("req_from_err_busy", 64'(busy), 64'd1);
    img_w[0] = 32'hDEAD_BEEF;
    load(1, 1'b0, -1);

    req_pulse();
    check("req2_hold", 64'(core_hold), 64'd1);
    img_w[0] = 32'h1234_5678;
    load(1, 1'b0, 2);

    img_w[0] = 32'hA1B2_C3D4;
    img_w[1] = 32'h0F1E_2D3C;
    req_pulse();
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    for (int b = 0; b < 4; b++) send_wbyte(0, b, 1'b0);
    send_wbyte(1, 0, 1'b0);
    errs = 0;
    for (int i = 0; i < 16; i++) begin
      if (err) errs++;
      @(negedge clk);
    end
    check("to_early_err", 64'(errs), 64'd0);
    check("to_err", 64'(err), 64'd1);
    check("to_hold", 64'(core_hold), 64'd1);
    check("to_busy", 64'(busy), 64'd0);

    req_pulse();
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    for (int b = 0; b < 4; b++) send_wbyte(0, b, 1'b0);
    send_wbyte(1, 0, 1'b0);
    errs = 0;
    for (int i = 0; i < 15; i++) begin
      if (err) errs++;
      @(negedge clk);
    end
    send_wbyte(1, 1, 1'b0);
    check("to_edge_early", 64'(errs), 64'd0);
    check("to_edge_err", 64'(err), 64'd0);
    send_wbyte(1, 2, 1'b0);
    send_wbyte(1, 3, 1'b0);
    check_release();

    req_pulse();
    img_w[0] = 32'h5555_AAAA;
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_wbyte(0, 0, 1'b0);
    send_wbyte(0, 1, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_we", 64'(imem_we), 64'd0);
    check("mid_rst_waddr", 64'(imem_waddr), 64'd0);
    check("mid_rst_wdata", 64'(imem_wdata), 64'd0);
    check("mid_rst_hold", 64'(core_hold), 64'd1);
    check("mid_rst_busy", 64'(busy), 64'd1);
    check("mid_rst_ready", 64'(byte_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    img_w[0] = 32'hCAFE_F00D;
    img_w[1] = 32'h8765_4321;
    load(2, 1'b1, -1);

    repeat (3) @(negedge clk);
    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
